// File: rtl/regalu_control_fsm.sv
// Multi-cycle control FSM for the register-block/ALU datapath: fetch, decode,
// execute, memory and writeback sequencing with overflow trap handling.
module regalu_control_fsm #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned IMMW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_ready,
  input  logic            overflow,
  output logic            mem_read,
  output logic            fetch,
  output logic            ir_write,
  output logic            pc_write,
  output logic [IMMW-1:0] imm_out,
  output logic            mary_write,
  output logic            shelley_write,
  output logic            comp_write,
  output logic            ra_write,
  output logic [1:0]      mary_src,
  output logic [1:0]      shelley_src,
  output logic            ra_src,
  output logic            SrcA,
  output logic [1:0]      SrcB,
  output logic [3:0]      AluOp,
  output logic            ov_trap,
  output logic            illegal,
  output logic            busy
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  localparam logic [OPW-1:0] OpAdd   = OPW'(0);
  localparam logic [OPW-1:0] OpSub   = OPW'(1);
  localparam logic [OPW-1:0] OpAddi  = OPW'(2);
  localparam logic [OPW-1:0] OpOri   = OPW'(3);
  localparam logic [OPW-1:0] OpLw    = OPW'(4);
  localparam logic [OPW-1:0] OpLi    = OPW'(5);
  localparam logic [OPW-1:0] OpCmp   = OPW'(6);
  localparam logic [OPW-1:0] OpJal   = OPW'(7);
  localparam logic [OPW-1:0] OpSpadd = OPW'(8);

  state_e          state_q;
  logic [OPW-1:0]  op_q;
  logic [IMMW-1:0] imm_q;
  logic            legal;

  // Bits between opcode and immediate are decoded by the datapath, not here.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[15-OPW:IMMW];

  assign legal = (op_q <= OpSpadd);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFetch;
      op_q    <= '0;
      imm_q   <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (mem_ready) begin
            op_q    <= mem_rdata[15 -: OPW];
            imm_q   <= mem_rdata[IMMW-1:0];
            state_q <= StDecode;
          end
        end
        StDecode: state_q <= legal ? StExec : StFetch;
        StExec: begin
          if (op_q == OpLw)       state_q <= StMem;
          else if (op_q == OpJal) state_q <= StFetch;
          else                    state_q <= StWb;
        end
        StMem:   if (mem_ready) state_q <= StWb;
        StWb:    state_q <= StFetch;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Outputs decode state; handshake pulses and the overflow squash must react
  // in the same cycle, and reset blanks everything so no pulse escapes.
  always_comb begin
    mem_read      = 1'b0;
    fetch         = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    imm_out       = '0;
    mary_write    = 1'b0;
    shelley_write = 1'b0;
    comp_write    = 1'b0;
    ra_write      = 1'b0;
    mary_src      = 2'd0;
    shelley_src   = 2'd0;
    ra_src        = 1'b0;
    SrcA          = 1'b0;
    SrcB          = 2'd0;
    AluOp         = 4'd0;
    ov_trap       = 1'b0;
    illegal       = 1'b0;
    busy          = 1'b0;
    if (!reset) begin
      busy    = (state_q != StFetch);
      imm_out = (state_q == StFetch) ? '0 : imm_q;
      unique case (state_q)
        StFetch: begin
          mem_read = 1'b1;
          fetch    = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        StDecode: illegal = !legal;
        StExec: begin
          case (op_q)
            OpSub:   AluOp = 4'd1;
            OpAddi:  SrcB  = 2'd2;
            OpOri: begin
              SrcB  = 2'd1;
              AluOp = 4'd3;
            end
            OpLw:    SrcB  = 2'd2;
            OpCmp:   AluOp = 4'd1;
            OpJal: begin
              ra_write = 1'b1;
              ra_src   = 1'b0;
              pc_write = 1'b1;
            end
            OpSpadd: begin
              SrcA = 1'b1;
              SrcB = 2'd3;
            end
            default: ;
          endcase
        end
        StMem: mem_read = 1'b1;
        StWb: begin
          case (op_q)
            OpAdd, OpSub, OpAddi, OpSpadd: begin
              mary_write = !overflow;
              ov_trap    = overflow;
            end
            OpOri: mary_write = 1'b1;
            OpLw: begin
              mary_write = 1'b1;
              mary_src   = 2'd1;
            end
            OpLi: begin
              shelley_write = 1'b1;
              shelley_src   = 2'd2;
            end
            OpCmp: begin
              comp_write = !overflow;
              ov_trap    = overflow;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
